// File: rtl/encrypter.sv
// Frame encrypter: streams one PIXELS-byte frame from the plaintext RAM, XORs it with the key and writes the ciphertext to the same address.
// Optional feature macro: ENCRYPTER_ROLLING_KEY_EN (key rotates left by one after every byte written).
module encrypter #(
  parameter logic [7:0] KEY    = 8'hB3,
  parameter int         PIXELS = 30625,
  parameter int         ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        plain_data,
  output logic [ADDR_W-1:0] read_addr,
  output logic              read_en,
  output logic [7:0]        cipher_data,
  output logic [ADDR_W-1:0] write_addr,
  output logic              write_en,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              rd_v1_q, rd_v2_q;
  logic [ADDR_W-1:0] addr_p1_q;
  logic [7:0]        cipher_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        cur_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = rd_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        rd_addr_d = '0;
        rd_en_d   = 1'b0;
        busy_d    = 1'b0;
        if (start) begin
          state_d = RUN;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // The last address stays on the bus for its read cycle; it is never incremented past.
        if (rd_addr_q == LAST) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (rd_v2_q && (wr_addr_q == LAST)) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rd_addr_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ENCRYPTER_ROLLING_KEY_EN
  logic [7:0] key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      key_q <= KEY;
    end else if (rd_v1_q) begin
      key_q <= {key_q[6:0], key_q[7]};
    end
  end

  assign cur_key = key_q;
`else
  assign cur_key = KEY;
`endif

  // Stage p1: RAM has sampled the address; stage p2: ciphertext and write strobe registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1_q   <= 1'b0;
      rd_v2_q   <= 1'b0;
      addr_p1_q <= '0;
      cipher_q  <= '0;
      wr_addr_q <= '0;
    end else begin
      rd_v1_q   <= rd_en_q;
      addr_p1_q <= rd_addr_q;
      rd_v2_q   <= rd_v1_q;
      if (rd_v1_q) begin
        cipher_q  <= plain_data ^ cur_key;
        wr_addr_q <= addr_p1_q;
      end
    end
  end

  assign read_addr   = rd_addr_q;
  assign read_en     = rd_en_q;
  assign cipher_data = cipher_q;
  assign write_addr  = wr_addr_q;
  assign write_en    = rd_v2_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_encrypter.sv
// Scoreboard bench for encrypter: a full-size instance and a PIXELS=4 instance, each fed by a one-cycle-latency RAM model.
module tb_encrypter;

  localparam int PA = 30625;
  localparam int PB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  a_plain = '0, b_plain = '0;
  logic [14:0] a_raddr, a_waddr;
  logic [2:0]  b_raddr, b_waddr;
  logic        a_ren, a_wen, a_busy, a_done;
  logic        b_ren, b_wen, b_busy, b_done;
  logic [7:0]  a_cipher, b_cipher;

  encrypter dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .plain_data(a_plain),
    .read_addr(a_raddr), .read_en(a_ren), .cipher_data(a_cipher),
    .write_addr(a_waddr), .write_en(a_wen), .busy(a_busy), .done(a_done)
  );

  encrypter #(.PIXELS(PB), .ADDR_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .plain_data(b_plain),
    .read_addr(b_raddr), .read_en(b_ren), .cipher_data(b_cipher),
    .write_addr(b_waddr), .write_en(b_wen), .busy(b_busy), .done(b_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pmode   = 0;

  logic [22:0] qa[$];
  logic [10:0] qb[$];

  function automatic logic [7:0] pat(input int m, input int a);
    logic [31:0] v;
    case (m)
      0:       v = a;
      1:       v = 0;
      default: v = a * 7 + 3;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [7:0] key_at(input int a);
    logic [7:0] k;
    k = 8'hB3;
`ifdef ENCRYPTER_ROLLING_KEY_EN
    for (int i = 0; i < (a % 8); i++) k = {k[6:0], k[7]};
`endif
    return k;
  endfunction

  // RAM models: the byte read for an address is known here, so its expected ciphertext is queued now.
  always @(posedge clk) begin
    if (a_ren) begin
      a_plain <= pat(pmode, int'(a_raddr));
      qa.push_back({a_raddr, pat(pmode, int'(a_raddr)) ^ key_at(int'(a_raddr))});
    end
    if (b_ren) begin
      b_plain <= pat(pmode, int'(b_raddr));
      qb.push_back({b_raddr, pat(pmode, int'(b_raddr)) ^ key_at(int'(b_raddr))});
    end
  end

  task automatic test_reset();
    int act;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({a_raddr, a_ren, a_cipher, a_waddr, a_wen, a_busy, a_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: outputs=%h required 0", {a_raddr, a_ren, a_cipher, a_waddr, a_wen, a_busy, a_done});
    end
    n_tests++;
    if ({b_raddr, b_ren, b_cipher, b_waddr, b_wen, b_busy, b_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: outputs=%h required 0", {b_raddr, b_ren, b_cipher, b_waddr, b_wen, b_busy, b_done});
    end
    @(negedge clk) rst_n = 1'b1;
    act = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (a_wen || a_ren || a_busy || a_done || b_wen || b_ren || b_busy || b_done) act++;
    end
    n_tests++;
    if (act !== 0) begin
      n_fail++;
      $display("FAIL idle_quiet: active cycles=%0d required 0", act);
    end
    qa.delete(); qb.delete();
  endtask

  task automatic test_full_frame();
    int nw = 0, bad = 0, done_cyc = -1, ndone = 0, rviol = 0;
    logic [7:0] v0 = 'x, v5 = 'x, vl = 'x;
    logic busy_late = 1'b0, busy_done = 1'b1;
    logic [22:0] e;
    logic [7:0] exp5;
`ifdef ENCRYPTER_ROLLING_KEY_EN
    exp5 = 8'h73;
`else
    exp5 = 8'hB6;
`endif
    pmode = 0;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n_tests++;
    if ({a_ren, a_raddr, a_busy} !== {1'b1, 15'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL start_accept: ren/raddr/busy=%b/%0d/%b required 1/0/1", a_ren, a_raddr, a_busy);
    end
    for (int cyc = 1; cyc <= PA + 10 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      if (a_raddr > 15'(PA - 1)) rviol++;
      if (cyc == PA + 1) busy_late = a_busy;
      if (a_done) begin
        ndone++; done_cyc = cyc; busy_done = a_busy;
      end
      if (a_wen) begin
        nw++;
        if (qa.size() == 0) begin
          bad++;
        end else begin
          e = qa.pop_front();
          if ({a_waddr, a_cipher} !== e) begin
            if (bad == 0) $display("FAIL frame_write: addr/data=%0d/%h required %0d/%h", a_waddr, a_cipher, e[22:8], e[7:0]);
            bad++;
          end
        end
        if (a_waddr == 15'd0) v0 = a_cipher;
        if (a_waddr == 15'd5) v5 = a_cipher;
        if (a_waddr == 15'(PA - 1)) vl = a_cipher;
      end
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL frame_data: bad writes=%0d required 0", bad); end
    n_tests++; if (nw !== PA) begin n_fail++; $display("FAIL frame_count: writes=%0d required %0d", nw, PA); end
    n_tests++; if (v0 !== 8'hB3) begin n_fail++; $display("FAIL addr0: data=%h required b3", v0); end
    n_tests++; if (v5 !== exp5) begin n_fail++; $display("FAIL addr5: data=%h required %h", v5, exp5); end
    n_tests++; if (vl !== 8'h13) begin n_fail++; $display("FAIL addr_last: data=%h required 13", vl); end
    n_tests++; if (done_cyc !== PA + 2) begin n_fail++; $display("FAIL done_time: cycle=%0d required %0d", done_cyc, PA + 2); end
    n_tests++; if (busy_late !== 1'b1) begin n_fail++; $display("FAIL busy_last_write: busy=%b required 1", busy_late); end
    n_tests++; if (busy_done !== 1'b0) begin n_fail++; $display("FAIL busy_in_done: busy=%b required 0", busy_done); end
    n_tests++; if (rviol !== 0) begin n_fail++; $display("FAIL read_range: violations=%0d required 0", rviol); end
    @(posedge clk); #1;
    n_tests++;
    if ({a_done, a_busy, a_ren} !== 3'b000) begin
      n_fail++;
      $display("FAIL done_pulse: done/busy/ren=%b/%b/%b required 0/0/0", a_done, a_busy, a_ren);
    end
    qa.delete();
  endtask

  task automatic test_busy_start();
    int nw = 0, bad = 0, ndone = 0, act = 0;
    logic [22:0] e;
    pmode = 2;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int cyc = 1; cyc <= PA + 10 && ndone == 0; cyc++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      if (a_wen) begin
        nw++;
        if (qa.size() == 0) begin
          bad++;
        end else begin
          e = qa.pop_front();
          if ({a_waddr, a_cipher} !== e) begin
            if (bad == 0) $display("FAIL busy_write: addr/data=%0d/%h required %0d/%h", a_waddr, a_cipher, e[22:8], e[7:0]);
            bad++;
          end
        end
        if (a_waddr == 15'd50) start_a = 1'b1;
      end
      if (a_done) begin
        ndone++;
        start_a = 1'b1;
      end
    end
    @(posedge clk); #1 start_a = 1'b0;
    repeat (6) begin
      if (a_busy || a_ren || a_wen || a_done) act++;
      @(posedge clk); #1;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL busy_data: bad writes=%0d required 0", bad); end
    n_tests++; if (nw !== PA) begin n_fail++; $display("FAIL busy_count: writes=%0d required %0d", nw, PA); end
    n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL busy_done: done pulses=%0d required 1", ndone); end
    n_tests++; if (act !== 0) begin n_fail++; $display("FAIL ignored_start: active cycles=%0d required 0", act); end
    qa.delete();
  endtask

  task automatic test_mid_reset();
    int first_cyc = -1, bad = 0;
    logic hit = 1'b0;
    logic [14:0] first_addr = 'x;
    logic [7:0] v[9];
    logic [7:0] ex[9];
    logic [22:0] e;
`ifdef ENCRYPTER_ROLLING_KEY_EN
    ex = '{8'hB3, 8'h67, 8'hCE, 8'h9D, 8'h3B, 8'h76, 8'hEC, 8'hD9, 8'hB3};
`else
    ex = '{default: 8'hB3};
`endif
    for (int i = 0; i < 9; i++) v[i] = 'x;
    pmode = 0;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int cyc = 1; cyc <= 200 && !hit; cyc++) begin
      @(posedge clk); #1;
      if (a_wen && a_waddr == 15'd100) hit = 1'b1;
    end
    n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL reach_addr100: reached=%b required 1", hit); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a_raddr, a_ren, a_cipher, a_waddr, a_wen, a_busy, a_done} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: outputs=%h required 0", {a_raddr, a_ren, a_cipher, a_waddr, a_wen, a_busy, a_done});
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    qa.delete(); qb.delete();
    pmode = 1;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (a_wen) begin
        if (first_cyc < 0) begin first_cyc = cyc; first_addr = a_waddr; end
        if (a_waddr < 15'd9) v[a_waddr] = a_cipher;
        if (qa.size() == 0) begin
          bad++;
        end else begin
          e = qa.pop_front();
          if ({a_waddr, a_cipher} !== e) bad++;
        end
      end
    end
    n_tests++; if (first_cyc !== 2 || first_addr !== 15'd0) begin n_fail++; $display("FAIL restart_first: cycle/addr=%0d/%0d required 2/0", first_cyc, first_addr); end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL restart_data: bad writes=%0d required 0", bad); end
    n_tests++; if (v[0] !== ex[0]) begin n_fail++; $display("FAIL zero_addr0: data=%h required %h", v[0], ex[0]); end
    n_tests++; if (v[1] !== ex[1]) begin n_fail++; $display("FAIL zero_addr1: data=%h required %h", v[1], ex[1]); end
    n_tests++; if (v[2] !== ex[2]) begin n_fail++; $display("FAIL zero_addr2: data=%h required %h", v[2], ex[2]); end
    n_tests++; if (v[8] !== ex[8]) begin n_fail++; $display("FAIL zero_addr8: data=%h required %h", v[8], ex[8]); end
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    qa.delete(); qb.delete();
  endtask

  task automatic test_boundary();
    int nw = 0, bad = 0, rviol = 0, wviol = 0, d1 = -1, d2 = -1;
    logic restart_ok = 1'b0;
    logic [10:0] e;
    pmode = 2;
    @(negedge clk) start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int cyc = 1; cyc <= 30 && d2 < 0; cyc++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      if (b_raddr > 3'd3) rviol++;
      if (b_wen) begin
        nw++;
        if (b_waddr > 3'd3) wviol++;
        if (qb.size() == 0) begin
          bad++;
        end else begin
          e = qb.pop_front();
          if ({b_waddr, b_cipher} !== e) begin
            if (bad == 0) $display("FAIL small_write: addr/data=%0d/%h required %0d/%h", b_waddr, b_cipher, e[10:8], e[7:0]);
            bad++;
          end
        end
      end
      if (b_done) begin
        if (d1 < 0) d1 = cyc; else d2 = cyc;
      end
      if (d1 > 0 && cyc == d1 + 1) start_b = 1'b1;
      if (d1 > 0 && cyc == d1 + 2) restart_ok = b_busy && b_ren && (b_raddr == 3'd0);
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL small_data: bad writes=%0d required 0", bad); end
    n_tests++; if (nw !== 2 * PB) begin n_fail++; $display("FAIL small_count: writes=%0d required %0d", nw, 2 * PB); end
    n_tests++; if (rviol !== 0 || wviol !== 0) begin n_fail++; $display("FAIL small_range: read/write violations=%0d/%0d required 0/0", rviol, wviol); end
    n_tests++; if (d1 !== PB + 2) begin n_fail++; $display("FAIL small_done: cycle=%0d required %0d", d1, PB + 2); end
    n_tests++; if (restart_ok !== 1'b1) begin n_fail++; $display("FAIL back_to_back: restarted=%b required 1", restart_ok); end
    n_tests++; if (d2 !== 2 * PB + 6) begin n_fail++; $display("FAIL back_to_back_done: cycle=%0d required %0d", d2, 2 * PB + 6); end
    qb.delete();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_busy_start();
    test_mid_reset();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
